fx2_slave_fifo: RTL and testbench



---
 rtl/fx2_pkg.sv | 22 ++
 rtl/fx2_ep_fifo.sv | 87 ++++++++
 rtl/fx2_slave_fifo.sv | 174 +++++++++++++++++
 tb/tb_fx2_slave_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_pkg
//  Description : Shared constants for the FX2 slave-FIFO responder: FIFOADR
//                endpoint codes and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fx2_pkg;

  // FIFOADR endpoint selects as seen on the slave-FIFO address pins
  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  // Default geometry: 16-bit bus, 512-word endpoint FIFOs, 512-byte packets
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH_LOG2 = 9;
  localparam int DEF_PKT_WORDS  = 256;

endpackage
`default_nettype wire

// File: rtl/fx2_ep_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_ep_fifo
//  Description : Single-clock endpoint FIFO with a per-word "last" bit.
//                Writes land behind a commit pointer; only committed words
//                are visible to the reader. i_commit moves the commit pointer
//                up to the write pointer (including a word written in the
//                same cycle). Committing without a same-cycle write marks
//                the newest pending word as last.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx2_ep_fifo
  import fx2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_last,
  input  logic                  i_commit,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic [DEPTH_LOG2:0]   o_total_count,
  output logic [DEPTH_LOG2:0]   o_commit_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   cm_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2:0]   wr_ptr_next;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] prev_idx;
  logic                  pending_nz;
  logic                  mark_prev;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  last_mem [DEPTH];

  assign wr_ptr_next = wr_ptr + CNT_W'(i_wr_en);
  assign wr_idx      = wr_ptr[DEPTH_LOG2-1:0];
  assign prev_idx    = wr_idx - 1'b1;
  assign pending_nz  = (wr_ptr != cm_ptr);
  assign mark_prev   = i_commit && !i_wr_en && pending_nz;

  // Storage write; a bare commit retro-tags the newest pending word as last
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      data_mem[wr_idx] <= i_wr_data;
      last_mem[wr_idx] <= i_wr_last;
    end
    if (mark_prev) begin
      last_mem[prev_idx] <= 1'b1;
    end
  end

  // Pointer bookkeeping; reset discards committed and pending contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      if (i_commit) begin
        cm_ptr <= wr_ptr_next;
      end
      if (i_rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign o_rd_data      = data_mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign o_rd_last      = last_mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign o_total_count  = wr_ptr - rd_ptr;
  assign o_commit_count = cm_ptr - rd_ptr;

endmodule
`default_nettype wire

// File: rtl/fx2_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_slave_fifo
//  Description : Bus-functional model of the FX2 (CY68013) slave-FIFO chip
//                side. EP2 (OUT) is filled by a host push stream and drained
//                by SLRD; EP6 (IN) is filled by SLWR, committed per packet
//                (PKTEND or auto at PKT_WORDS) and drained by a host pop
//                stream.
//                Build option: define FX2_FLAG_LATENCY_EN to register
//                FLAGA/FLAGD so they lag occupancy by one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx2_slave_fifo
  import fx2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int PKT_WORDS  = DEF_PKT_WORDS
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst,
  inout  wire  [DATA_WIDTH-1:0] io_usb_data,
  input  logic [1:0]            i_usb_addr,
  input  logic                  i_usb_slrd,
  input  logic                  i_usb_slwr,
  input  logic                  i_usb_sloe,
  input  logic                  i_usb_pkend,
  output logic                  o_usb_flaga,
  output logic                  o_usb_flagd,
  input  logic [DATA_WIDTH-1:0] i_host_ep2_data,
  input  logic                  i_host_ep2_valid,
  output logic                  o_host_ep2_ready,
  output logic [DATA_WIDTH-1:0] o_host_ep6_data,
  output logic                  o_host_ep6_valid,
  output logic                  o_host_ep6_last,
  input  logic                  i_host_ep6_ready,
  output logic                  o_ep6_zlp,
  output logic                  o_err_underrun,
  output logic                  o_err_overflow
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] PKT_LAST = CNT_W'(PKT_WORDS - 1);

  // ---------------- EP2: host -> master ----------------
  logic [DATA_WIDTH-1:0] ep2_head;
  logic [DEPTH_LOG2:0]   ep2_total;
  logic [DEPTH_LOG2:0]   ep2_avail;
  logic                  unused_ep2_last;
  logic                  ep2_empty;
  logic                  ep2_full;
  logic                  ep2_rd_stb;
  logic                  ep2_pop;
  logic                  ep2_push;
  logic [DATA_WIDTH-1:0] last_popped;
  logic                  bus_drive;

  assign ep2_empty        = (ep2_avail == '0);
  assign ep2_full         = (ep2_total == FULL_CNT);
  assign ep2_rd_stb       = !i_usb_slrd && (i_usb_addr == EP2);
  assign ep2_pop          = ep2_rd_stb && !ep2_empty;
  assign o_host_ep2_ready = !ep2_full;
  assign ep2_push         = i_host_ep2_valid && !ep2_full;

  fx2_ep_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ep2 (
    .clk            (i_usb_ifclk),
    .rst            (i_rst),
    .i_wr_en        (ep2_push),
    .i_wr_data      (i_host_ep2_data),
    .i_wr_last      (1'b1),
    .i_commit       (1'b1),
    .i_rd_en        (ep2_pop),
    .o_rd_data      (ep2_head),
    .o_rd_last      (unused_ep2_last),
    .o_total_count  (ep2_total),
    .o_commit_count (ep2_avail)
  );

  // Hold the most recently consumed word so an empty FIFO still shows it
  always_ff @(posedge i_usb_ifclk or posedge i_rst) begin
    if (i_rst) begin
      last_popped <= '0;
    end else if (ep2_pop) begin
      last_popped <= ep2_head;
    end
  end

  // FX2 drives the bus only for an EP2 read with SLOE asserted
  assign bus_drive   = !i_usb_sloe && (i_usb_addr == EP2);
  assign io_usb_data = bus_drive ? (ep2_empty ? last_popped : ep2_head)
                                 : {DATA_WIDTH{1'bz}};

  // ---------------- EP6: master -> host ----------------
  logic [DEPTH_LOG2:0] ep6_total;
  logic [DEPTH_LOG2:0] ep6_avail;
  logic [DEPTH_LOG2:0] ep6_pending;
  logic                ep6_full;
  logic                ep6_wr_stb;
  logic                ep6_push;
  logic                ep6_pkend;
  logic                ep6_auto;
  logic                ep6_commit;
  logic                ep6_pop;
  logic                zlp_now;

  assign ep6_full    = (ep6_total == FULL_CNT);
  assign ep6_pending = ep6_total - ep6_avail;
  assign ep6_wr_stb  = !i_usb_slwr && (i_usb_addr == EP6);
  assign ep6_push    = ep6_wr_stb && !ep6_full;
  assign ep6_pkend   = !i_usb_pkend && (i_usb_addr == EP6);
  // The write that brings the packet to PKT_WORDS closes it in the same edge
  assign ep6_auto    = ep6_push && (ep6_pending == PKT_LAST);
  assign ep6_commit  = ep6_pkend || ep6_auto;
  assign zlp_now     = ep6_pkend && (ep6_pending == '0) && !ep6_wr_stb;
  assign o_host_ep6_valid = (ep6_avail != '0);
  assign ep6_pop     = o_host_ep6_valid && i_host_ep6_ready;

  fx2_ep_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ep6 (
    .clk            (i_usb_ifclk),
    .rst            (i_rst),
    .i_wr_en        (ep6_push),
    .i_wr_data      (io_usb_data),
    .i_wr_last      (ep6_commit),
    .i_commit       (ep6_commit),
    .i_rd_en        (ep6_pop),
    .o_rd_data      (o_host_ep6_data),
    .o_rd_last      (o_host_ep6_last),
    .o_total_count  (ep6_total),
    .o_commit_count (ep6_avail)
  );

  // ZLP pulse and sticky strobe-misuse detectors
  always_ff @(posedge i_usb_ifclk or posedge i_rst) begin
    if (i_rst) begin
      o_ep6_zlp      <= 1'b0;
      o_err_underrun <= 1'b0;
      o_err_overflow <= 1'b0;
    end else begin
      o_ep6_zlp <= zlp_now;
      if (ep2_rd_stb && ep2_empty) begin
        o_err_underrun <= 1'b1;
      end
      if (ep6_wr_stb && ep6_full) begin
        o_err_overflow <= 1'b1;
      end
    end
  end

  // ---------------- Status flags ----------------
`ifdef FX2_FLAG_LATENCY_EN
  // Registered flags reproduce the one-clock lag of the real chip
  always_ff @(posedge i_usb_ifclk or posedge i_rst) begin
    if (i_rst) begin
      o_usb_flaga <= 1'b0;
      o_usb_flagd <= 1'b1;
    end else begin
      o_usb_flaga <= !ep2_empty;
      o_usb_flagd <= !ep6_full;
    end
  end
`else
  assign o_usb_flaga = !ep2_empty;
  assign o_usb_flagd = !ep6_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fx2_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx2_slave_fifo
//  Description : Directed self-checking bench for fx2_slave_fifo (default
//                build, combinational flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx2_slave_fifo;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] usb_data;
  logic        tb_drv;
  logic [15:0] tb_word;
  logic [1:0]  addr;
  logic        slrd, slwr, sloe, pkend;
  logic        flaga, flagd;
  logic [15:0] h2_data;
  logic        h2_valid, h2_ready;
  logic [15:0] h6_data;
  logic        h6_valid, h6_last, h6_ready;
  logic        zlp, err_under, err_over;

  int checks = 0;
  int errors = 0;

  assign usb_data = tb_drv ? tb_word : 16'bz;

  always #5 clk = ~clk;

  fx2_slave_fifo dut (
    .i_usb_ifclk      (clk),
    .i_rst            (rst),
    .io_usb_data      (usb_data),
    .i_usb_addr       (addr),
    .i_usb_slrd       (slrd),
    .i_usb_slwr       (slwr),
    .i_usb_sloe       (sloe),
    .i_usb_pkend      (pkend),
    .o_usb_flaga      (flaga),
    .o_usb_flagd      (flagd),
    .i_host_ep2_data  (h2_data),
    .i_host_ep2_valid (h2_valid),
    .o_host_ep2_ready (h2_ready),
    .o_host_ep6_data  (h6_data),
    .o_host_ep6_valid (h6_valid),
    .o_host_ep6_last  (h6_last),
    .i_host_ep6_ready (h6_ready),
    .o_ep6_zlp        (zlp),
    .o_err_underrun   (err_under),
    .o_err_overflow   (err_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_drv = 1'b0; tb_word = 16'h0; addr = 2'b01;
    slrd = 1'b1; slwr = 1'b1; sloe = 1'b1; pkend = 1'b1;
    h2_data = 16'h0; h2_valid = 1'b0; h6_ready = 1'b0;
    #2;
    checks++; if (flaga !== 1'b0) begin errors++; $display("FAIL reset_flaga: got %b expected 0", flaga); end
    checks++; if (flagd !== 1'b1) begin errors++; $display("FAIL reset_flagd: got %b expected 1", flagd); end
    checks++; if (h2_ready !== 1'b1) begin errors++; $display("FAIL reset_ep2_ready: got %b expected 1", h2_ready); end
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL reset_ep6_valid: got %b expected 0", h6_valid); end
    checks++; if (zlp !== 1'b0) begin errors++; $display("FAIL reset_zlp: got %b expected 0", zlp); end
    checks++; if (err_under !== 1'b0 || err_over !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", err_under, err_over); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ep2_read();
    h2_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      h2_data = 16'(i);
      tick();
    end
    h2_valid = 1'b0;
    #1;
    checks++; if (flaga !== 1'b1) begin errors++; $display("FAIL ep2_flaga_filled: got %b expected 1", flaga); end
    sloe = 1'b0; addr = 2'b00;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (usb_data !== 16'(k + 1)) begin errors++; $display("FAIL ep2_bus[%0d]: got %h expected %h", k, usb_data, 16'(k + 1)); end
      slrd = 1'b0;
      tick();
      slrd = 1'b1;
      tick();
    end
    #1;
    checks++; if (flaga !== 1'b0) begin errors++; $display("FAIL ep2_flaga_drained: got %b expected 0", flaga); end
    checks++; if (err_under !== 1'b0) begin errors++; $display("FAIL ep2_no_underrun: got %b expected 0", err_under); end
    checks++; if (usb_data !== 16'h0010) begin errors++; $display("FAIL ep2_bus_hold: got %h expected 0010", usb_data); end
    sloe = 1'b1; addr = 2'b01;
    tick();
  endtask

  task automatic test_ep6_pkend();
    addr = 2'b10; tb_drv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tb_word = 16'hA000 + 16'(i);
      slwr = 1'b0;
      pkend = (i == 4) ? 1'b0 : 1'b1;
      if (i == 4) begin
        #1;
        checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL pkend_valid_early: got %b expected 0", h6_valid); end
      end
      tick();
    end
    slwr = 1'b1; pkend = 1'b1; tb_drv = 1'b0; addr = 2'b01;
    #1;
    checks++; if (h6_valid !== 1'b1) begin errors++; $display("FAIL pkend_valid: got %b expected 1", h6_valid); end
    h6_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (h6_data !== 16'hA000 + 16'(i) || h6_last !== (i == 4)) begin
        errors++; $display("FAIL pkend_pop[%0d]: got %h/%b expected %h/%b", i, h6_data, h6_last, 16'hA000 + 16'(i), (i == 4));
      end
      tick();
    end
    h6_ready = 1'b0;
    #1;
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL pkend_drained: got %b expected 0", h6_valid); end
  endtask

  task automatic test_auto_commit();
    addr = 2'b10; tb_drv = 1'b1; slwr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_word = 16'h1000 + 16'(i);
      if (i == 255) begin
        #1;
        checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL auto_valid_early: got %b expected 0", h6_valid); end
      end
      tick();
    end
    slwr = 1'b1; tb_drv = 1'b0; addr = 2'b01;
    #1;
    checks++; if (h6_valid !== 1'b1) begin errors++; $display("FAIL auto_valid: got %b expected 1", h6_valid); end
    h6_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      checks++;
      if (h6_data !== 16'h1000 + 16'(i) || h6_last !== (i == 255)) begin
        errors++; $display("FAIL auto_pop[%0d]: got %h/%b expected %h/%b", i, h6_data, h6_last, 16'h1000 + 16'(i), (i == 255));
      end
      tick();
    end
    h6_ready = 1'b0;
  endtask

  task automatic test_zlp();
    addr = 2'b10; pkend = 1'b0;
    tick();
    pkend = 1'b1; addr = 2'b01;
    #1;
    checks++; if (zlp !== 1'b1) begin errors++; $display("FAIL zlp_pulse: got %b expected 1", zlp); end
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL zlp_no_entry: got %b expected 0", h6_valid); end
    tick();
    checks++; if (zlp !== 1'b0) begin errors++; $display("FAIL zlp_one_cycle: got %b expected 0", zlp); end
  endtask

  task automatic test_overflow_underrun();
    addr = 2'b10; tb_drv = 1'b1; slwr = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tb_word = 16'(i);
      tick();
    end
    checks++; if (err_over !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", err_over); end
    checks++; if (flagd !== 1'b0) begin errors++; $display("FAIL ovf_flagd_full: got %b expected 0", flagd); end
    tb_word = 16'hDEAD;
    tick();
    slwr = 1'b1; tb_drv = 1'b0; addr = 2'b01;
    #1;
    checks++; if (err_over !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_over); end
    h6_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      #1;
      checks++;
      if (h6_data !== 16'(i) || h6_last !== (i == 255 || i == 511)) begin
        errors++; $display("FAIL ovf_pop[%0d]: got %h/%b expected %h/%b", i, h6_data, h6_last, 16'(i), (i == 255 || i == 511));
      end
      tick();
    end
    h6_ready = 1'b0;
    #1;
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL ovf_extra_word: got valid %b data %h expected valid 0", h6_valid, h6_data); end
    checks++; if (flagd !== 1'b1) begin errors++; $display("FAIL ovf_flagd_free: got %b expected 1", flagd); end
    checks++; if (err_under !== 1'b0) begin errors++; $display("FAIL unr_not_yet: got %b expected 0", err_under); end
    addr = 2'b00; slrd = 1'b0;
    tick();
    slrd = 1'b1; addr = 2'b01;
    #1;
    checks++; if (err_under !== 1'b1) begin errors++; $display("FAIL unr_flag: got %b expected 1", err_under); end
  endtask

  task automatic test_reset_mid_packet();
    h2_valid = 1'b1;
    h2_data = 16'h0055; tick();
    h2_data = 16'h0066; tick();
    h2_valid = 1'b0;
    addr = 2'b10; tb_drv = 1'b1; slwr = 1'b0;
    tb_word = 16'hC000; tick();
    tb_word = 16'hC001; tick();
    tb_word = 16'hC002;
    #1;
    checks++; if (flaga !== 1'b1) begin errors++; $display("FAIL rstmid_pre_flaga: got %b expected 1", flaga); end
    rst = 1'b1;
    #1;
    checks++; if (flaga !== 1'b0 || flagd !== 1'b1) begin errors++; $display("FAIL rstmid_flags: got %b%b expected 01", flaga, flagd); end
    checks++; if (err_under !== 1'b0 || err_over !== 1'b0) begin errors++; $display("FAIL rstmid_errs: got %b%b expected 00", err_under, err_over); end
    tick();
    rst = 1'b0; slwr = 1'b1; tb_drv = 1'b0; addr = 2'b01;
    tick();
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_data: got %b expected 0", h6_valid); end
    addr = 2'b10; pkend = 1'b0;
    tick();
    pkend = 1'b1; addr = 2'b01;
    #1;
    checks++; if (zlp !== 1'b1) begin errors++; $display("FAIL rstmid_pending_cleared: got zlp %b expected 1", zlp); end
    checks++; if (h6_valid !== 1'b0) begin errors++; $display("FAIL rstmid_still_empty: got %b expected 0", h6_valid); end
  endtask

  initial begin
    test_reset();
    test_ep2_read();
    test_ep6_pkend();
    test_auto_commit();
    test_zlp();
    test_overflow_underrun();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
